fir_out_serializer: RTL and testbench

- Downstream stage of the FIR core: takes 16-bit filter results and buffers them in a small FIFO.
- Emits each result as an 8-bit byte stream over a valid/ready handshake, low byte first.
- Lets the 16-bit FIR output leave the chip on a single 8-bit port under backpressure, with overflow reporting.

---
 rtl/fir_out_serializer.sv | 161 ++++++++++++++++
 tb/tb_fir_out_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_serializer.sv
// Buffers 16-bit FIR results in a small FIFO and streams them out low byte first over valid/ready.
// Optional FIR_SER_SYNC_EN prefixes every sample with SYNC_BYTE (3-byte frames).
module fir_out_serializer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef FIR_SER_SYNC_EN
  ,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [7:0]                  m_byte,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
`ifdef FIR_SER_SYNC_EN
    StSync = 2'd3,
`endif
    StHi   = 2'd2
  } state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              overflow_q;
  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic [7:0]        m_byte_q;
  logic              m_valid_q;

  logic              empty, full, push, pop;
  logic [DATA_W-1:0] head;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LvlW'(FIFO_DEPTH));
    head  = mem_q[rd_ptr_q];
    push  = s_valid && !full && !clear;
    // HI always has m_valid set, so m_ready alone marks the final byte transfer.
    pop   = !clear && !empty &&
            ((state_q == StIdle) || ((state_q == StHi) && m_valid_q && m_ready));
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      if (s_valid && full) overflow_q <= 1'b1;
    end
  end

  // A frame entered from IDLE spends one cycle with m_valid low before its first byte shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      m_byte_q  <= 8'h00;
      m_valid_q <= 1'b0;
    end else if (clear) begin
      state_q   <= StIdle;
      m_byte_q  <= 8'h00;
      m_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            hold_q  <= head;
`ifdef FIR_SER_SYNC_EN
            state_q <= StSync;
`else
            state_q <= StLo;
`endif
          end
        end
`ifdef FIR_SER_SYNC_EN
        StSync: begin
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_byte_q  <= SYNC_BYTE;
          end else if (m_ready) begin
            state_q  <= StLo;
            m_byte_q <= hold_q[7:0];
          end
        end
`endif
        StLo: begin
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_byte_q  <= hold_q[7:0];
          end else if (m_ready) begin
            state_q  <= StHi;
            m_byte_q <= hold_q[15:8];
          end
        end
        StHi: begin
          if (m_ready) begin
            if (!empty) begin
              hold_q <= head;
`ifdef FIR_SER_SYNC_EN
              state_q  <= StSync;
              m_byte_q <= SYNC_BYTE;
`else
              state_q  <= StLo;
              m_byte_q <= head[7:0];
`endif
            end else begin
              state_q   <= StIdle;
              m_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = !full;
  assign m_byte     = m_byte_q;
  assign m_valid    = m_valid_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Randomised self-checking bench for fir_out_serializer against a byte-queue reference model.
// Honours FIR_SER_SYNC_EN to expect 3-byte frames.
module tb_fir_out_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic [15:0]     s_data;
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      m_byte;
  logic            m_valid;
  logic            m_ready;
  logic [LvlW-1:0] fifo_level;
  logic            overflow;

  fir_out_serializer #(
    .DATA_W     (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_byte     (m_byte),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: samples waiting in the FIFO, bytes left of the current frame,
  // whether the head of that frame is currently presented, and the sticky drop flag.
  logic [15:0] mq[$];
  logic [7:0]  fb[$];
  bit          shown;
  bit          movf;

  logic [7:0]  log_q[$];
  bit          log_en;

  task automatic model_reset();
    mq.delete();
    fb.delete();
    shown = 0;
    movf  = 0;
  endtask

  task automatic load_frame(input logic [15:0] s);
    fb.delete();
`ifdef FIR_SER_SYNC_EN
    fb.push_back(SYNC);
`endif
    fb.push_back(s[7:0]);
    fb.push_back(s[15:8]);
  endtask

  task automatic model_step();
    bit full;
    bit push;
    if (clear) begin
      model_reset();
      return;
    end
    full = (mq.size() == DEPTH);
    push = s_valid && !full;
    if (s_valid && full) movf = 1;
    if (fb.size() == 0) begin
      if (mq.size() != 0) begin
        load_frame(mq.pop_front());
        shown = 0;
      end
    end else if (!shown) begin
      shown = 1;
    end else if (m_ready) begin
      void'(fb.pop_front());
      if (fb.size() == 0) begin
        if (mq.size() != 0) begin
          load_frame(mq.pop_front());
          shown = 1;
        end else begin
          shown = 0;
        end
      end
    end
    if (push) mq.push_back(s_data);
  endtask

  task automatic compare_all();
    check_eq("m_valid", m_valid, shown);
    if (shown) check_eq("m_byte", m_byte, fb[0]);
    check_eq("s_ready", s_ready, mq.size() != DEPTH);
    check_eq("fifo_level", fifo_level, mq.size());
    check_eq("overflow", overflow, movf);
  endtask

  task automatic cycle();
    if (log_en && m_valid && m_ready) log_q.push_back(m_byte);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run_idle(input int n);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    cycle();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_log[$];
    int guard;

    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    m_ready = 1'b0;
    log_en  = 0;
    model_reset();
    #22;
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_s_ready", s_ready, 1'b1);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_m_byte", m_byte, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Single sample, full-rate sink
    m_ready = 1'b1;
    send(16'h1234);
    check_eq("lat_edge1", m_valid, 1'b0);
    cycle();
    check_eq("lat_edge2", m_valid, 1'b0);
    cycle();
`ifdef FIR_SER_SYNC_EN
    check_eq("first_byte", m_byte, SYNC);
`else
    check_eq("first_byte", m_byte, 8'h34);
`endif
    check_eq("first_valid", m_valid, 1'b1);
    run_idle(6);

    // Backpressure holds the byte stable
    m_ready = 1'b0;
    send(16'hCAFE);
    repeat (6) cycle();
    m_ready = 1'b1;
    repeat (6) cycle();

    // Back-to-back samples
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    cycle();
    s_data  = 16'h0102;
    cycle();
    run_idle(10);

    // Overflow with a stalled sink
    log_q.delete();
    log_en  = 1;
    m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s_valid = 1'b1;
      s_data  = 16'(k);
      cycle();
    end
    s_valid = 1'b0;
    cycle();
    check_eq("ovf_level", fifo_level, DEPTH);
    check_eq("ovf_s_ready", s_ready, 1'b0);
    check_eq("ovf_flag", overflow, 1'b1);
    m_ready = 1'b1;
    repeat (20) cycle();
    log_en = 0;
    exp_log.delete();
    for (int k = 1; k <= 5; k++) begin
`ifdef FIR_SER_SYNC_EN
      exp_log.push_back(SYNC);
`endif
      exp_log.push_back(8'(k));
      exp_log.push_back(8'h00);
    end
    check_eq("ovf_log_len", log_q.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      check_eq("ovf_log_byte", log_q[i], exp_log[i]);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check_eq("clear_ovf", overflow, 1'b0);
    cycle();

    // Randomised traffic with occasional clear
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      clear   = ($urandom_range(0, 60) == 0);
      cycle();
    end
    clear = 1'b0;
    run_idle(12);

    // Asynchronous reset while the high byte is stalled
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h5A5A;
    cycle();
    s_data  = 16'h6B6B;
    cycle();
    s_data  = 16'h7C7C;
    cycle();
    s_valid = 1'b0;
    guard = 0;
    while (!(shown && fb.size() == 1) && guard < 20) begin
      cycle();
      guard++;
    end
    check_eq("reach_hi_timeout", guard < 20, 1'b1);
    m_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_m_valid", m_valid, 1'b0);
    check_eq("arst_level", fifo_level, 0);
    check_eq("arst_s_ready", s_ready, 1'b1);
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    run_idle(4);
    send(16'hABCD);
    run_idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
